// File: rtl/mem_access_stage_pkg.sv
// Shared encodings, widths and store/alignment helpers for the memory-access stage.
package mem_access_stage_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;

   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;
   localparam logic [DATA_W-1:0] ZERO = '0;

   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_LB   = 4'd1,
      OP_LH   = 4'd2,
      OP_LW   = 4'd3,
      OP_LBU  = 4'd4,
      OP_LHU  = 4'd5,
      OP_SB   = 4'd6,
      OP_SH   = 4'd7,
      OP_SW   = 4'd8
   } mem_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   function automatic logic is_valid_op(input logic [3:0] code);
      return (code >= 4'd1) && (code <= 4'd8);
   endfunction

   function automatic logic is_store(input mem_op_e op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] off);
      case (op)
         OP_LH, OP_LHU, OP_SH: return off[0];
         OP_LW, OP_SW:         return off != 2'b00;
         default:              return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] byte_enables(input mem_op_e op, input logic [1:0] off);
      case (op)
         OP_SB:   return 4'b0001 << off;
         OP_SH:   return 4'b0011 << off;
         default: return 4'b1111;
      endcase
   endfunction

   // Sub-word stores replicate across lanes; byte enables pick the live lane.
   function automatic logic [DATA_W-1:0] store_lanes(input mem_op_e op, input logic [DATA_W-1:0] d);
      case (op)
         OP_SB:   return {4{d[7:0]}};
         OP_SH:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Extracts the addressed byte/half from a bus read word and sign/zero extends it.
module mem_load_align
   import mem_access_stage_pkg::*;
(
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        off,
   input  logic [3:0]        op,
   output logic [DATA_W-1:0] value
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = rdata[{off, 3'b000} +: 8];
      half_v = rdata[{off[1], 4'b0000} +: 16];
      value  = rdata;
      case (mem_op_e'(op))
         OP_LB:   value = {{(DATA_W-8){byte_v[7]}}, byte_v};
         OP_LBU:  value = {{(DATA_W-8){1'b0}}, byte_v};
         OP_LH:   value = {{(DATA_W-16){half_v[15]}}, half_v};
         OP_LHU:  value = {{(DATA_W-16){1'b0}}, half_v};
         default: value = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: runs one req/ack bus transaction per load/store and feeds writeback.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned DATA_WIDTH     = DATA_W,
   parameter int unsigned ADDR_WIDTH     = ADDR_W
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [ADDR_WIDTH-1:0] mem_addr_i,
   input  logic [DATA_WIDTH-1:0] mem_data_i,
   input  logic                  mem_we_i,
   input  logic [3:0]            mem_op_i,
   input  logic                  reg_we_i,
   input  logic [4:0]            reg_waddr_i,
   input  logic [DATA_WIDTH-1:0] reg_wdata_i,
   output logic                  stall_o,
   output logic                  dbus_req_o,
   output logic                  dbus_we_o,
   output logic [ADDR_WIDTH-1:0] dbus_addr_o,
   output logic [3:0]            dbus_be_o,
   output logic [DATA_WIDTH-1:0] dbus_wdata_o,
   input  logic                  dbus_ack_i,
   input  logic [DATA_WIDTH-1:0] dbus_rdata_i,
   output logic                  wb_reg_we_o,
   output logic [4:0]            wb_reg_waddr_o,
   output logic [DATA_WIDTH-1:0] wb_reg_wdata_o,
   output logic                  err_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   mem_op_e                op_q, op_d;
   logic [1:0]             off_q, off_d;
   logic [4:0]             waddr_q, waddr_d;
   logic                   rwe_q, rwe_d;
   logic                   req_d, we_d, wb_we_d, err_d;
   logic [ADDR_WIDTH-1:0]  addr_d;
   logic [3:0]             be_d;
   logic [DATA_WIDTH-1:0]  wdata_d, wb_wdata_d, load_val;
   logic [4:0]             wb_waddr_d;
   mem_op_e                in_op;

   assign in_op = mem_op_e'(mem_op_i);

   mem_load_align u_load_align (
      .rdata (dbus_rdata_i),
      .off   (off_q),
      .op    (op_q),
      .value (load_val)
   );

   // Next-state, registered-output next values and the combinational stall.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      off_d      = off_q;
      waddr_d    = waddr_q;
      rwe_d      = rwe_q;
      req_d      = dbus_req_o;
      we_d       = dbus_we_o;
      addr_d     = dbus_addr_o;
      be_d       = dbus_be_o;
      wdata_d    = dbus_wdata_o;
      wb_we_d    = WRITE_DISABLE;
      wb_waddr_d = wb_reg_waddr_o;
      wb_wdata_d = wb_reg_wdata_o;
      err_d      = 1'b0;
      stall_o    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!is_valid_op(mem_op_i)) begin
               wb_we_d    = reg_we_i;
               wb_waddr_d = reg_waddr_i;
               wb_wdata_d = reg_wdata_i;
            end else if (is_misaligned(in_op, mem_addr_i[1:0])) begin
               err_d = 1'b1;
            end else begin
               stall_o = 1'b1;
               state_d = ST_BUSY;
               cnt_d   = '0;
               op_d    = in_op;
               off_d   = mem_addr_i[1:0];
               waddr_d = reg_waddr_i;
               rwe_d   = reg_we_i;
               req_d   = 1'b1;
               we_d    = mem_we_i & is_store(in_op);
               addr_d  = {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
               be_d    = byte_enables(in_op, mem_addr_i[1:0]);
               wdata_d = store_lanes(in_op, mem_data_i);
            end
         end
         ST_BUSY: begin
            stall_o = !dbus_ack_i;
            if (dbus_ack_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               req_d   = 1'b0;
               if (!is_store(op_q)) begin
                  wb_we_d    = rwe_q;
                  wb_waddr_d = waddr_q;
                  wb_wdata_d = load_val;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               // Final wait cycle: release upstream so the aborted op is dropped.
               stall_o = 1'b0;
               state_d = ST_IDLE;
               cnt_d   = '0;
               req_d   = 1'b0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         op_q           <= OP_NONE;
         off_q          <= 2'b00;
         waddr_q        <= 5'd0;
         rwe_q          <= 1'b0;
         dbus_req_o     <= 1'b0;
         dbus_we_o      <= WRITE_DISABLE;
         dbus_addr_o    <= '0;
         dbus_be_o      <= 4'b0000;
         dbus_wdata_o   <= '0;
         wb_reg_we_o    <= WRITE_DISABLE;
         wb_reg_waddr_o <= 5'd0;
         wb_reg_wdata_o <= '0;
         err_o          <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         op_q           <= op_d;
         off_q          <= off_d;
         waddr_q        <= waddr_d;
         rwe_q          <= rwe_d;
         dbus_req_o     <= req_d;
         dbus_we_o      <= we_d;
         dbus_addr_o    <= addr_d;
         dbus_be_o      <= be_d;
         dbus_wdata_o   <= wdata_d;
         wb_reg_we_o    <= wb_we_d;
         wb_reg_waddr_o <= wb_waddr_d;
         wb_reg_wdata_o <= wb_wdata_d;
         err_o          <= err_d;
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (TIMEOUT_CYCLES = 4).
module tb_mem_access_stage;
   import mem_access_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mem_addr, mem_data, reg_wdata, dbus_addr, dbus_wdata, dbus_rdata, wb_wdata;
   logic        mem_we, reg_we, stall, dbus_req, dbus_we, dbus_ack, wb_we, err;
   logic [3:0]  mem_op, dbus_be;
   logic [4:0]  reg_waddr, wb_waddr;

   int checks = 0;
   int errors = 0;

   mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .mem_addr_i     (mem_addr),
      .mem_data_i     (mem_data),
      .mem_we_i       (mem_we),
      .mem_op_i       (mem_op),
      .reg_we_i       (reg_we),
      .reg_waddr_i    (reg_waddr),
      .reg_wdata_i    (reg_wdata),
      .stall_o        (stall),
      .dbus_req_o     (dbus_req),
      .dbus_we_o      (dbus_we),
      .dbus_addr_o    (dbus_addr),
      .dbus_be_o      (dbus_be),
      .dbus_wdata_o   (dbus_wdata),
      .dbus_ack_i     (dbus_ack),
      .dbus_rdata_i   (dbus_rdata),
      .wb_reg_we_o    (wb_we),
      .wb_reg_waddr_o (wb_waddr),
      .wb_reg_wdata_o (wb_wdata),
      .err_o          (err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic we, input logic rwe, input logic [4:0] wa, input logic [31:0] wd);
      mem_op    = op;
      mem_addr  = addr;
      mem_data  = data;
      mem_we    = we;
      reg_we    = rwe;
      reg_waddr = wa;
      reg_wdata = wd;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; dbus_ack = 1'b0; dbus_rdata = 32'h0;
      drive(OP_NONE, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      tick(); tick();
      rst = 1'b0;
      #1;
      checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", dbus_req); end
      checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_wb_we got %0b want 0", wb_we); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall); end
      checks++; if ({dbus_addr, dbus_be, dbus_wdata, wb_wdata} !== 100'h0) begin errors++; $display("FAIL reset_data got %h/%h/%h/%h want 0", dbus_addr, dbus_be, dbus_wdata, wb_wdata); end
   endtask

   task automatic test_passthrough();
      drive(OP_NONE, 32'h0, 32'h0, 1'b0, 1'b1, 5'd5, 32'h1234);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL pass_stall got %0b want 0", stall); end
      tick();
      checks++; if (wb_we !== 1'b1 || wb_waddr !== 5'd5 || wb_wdata !== 32'h1234) begin errors++; $display("FAIL pass_wb got %0b/%0d/%h want 1/5/00001234", wb_we, wb_waddr, wb_wdata); end
      checks++; if (dbus_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL pass_bus got req %0b stall %0b want 0/0", dbus_req, stall); end
      drive(OP_NONE, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL pass_we_drop got %0b want 0", wb_we); end
   endtask

   task automatic test_lb_sign();
      drive(OP_LB, 32'h1003, 32'h0, 1'b0, 1'b1, 5'd7, 32'h0);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lb_accept_stall got %0b want 1", stall); end
      tick();
      checks++; if (dbus_req !== 1'b1 || dbus_addr !== 32'h1000 || dbus_be !== 4'b1111 || dbus_we !== 1'b0) begin errors++; $display("FAIL lb_bus got req %0b addr %h be %b we %0b want 1/00001000/1111/0", dbus_req, dbus_addr, dbus_be, dbus_we); end
      for (int i = 0; i < 2; i++) begin
         checks++; if (stall !== 1'b1 || wb_we !== 1'b0) begin errors++; $display("FAIL lb_wait%0d got stall %0b wb_we %0b want 1/0", i, stall, wb_we); end
         tick();
      end
      dbus_ack = 1'b1; dbus_rdata = 32'h80FF_FF00;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lb_ack_stall got %0b want 0", stall); end
      tick();
      dbus_ack = 1'b0;
      drive(OP_NONE, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      checks++; if (wb_we !== 1'b1 || wb_waddr !== 5'd7 || wb_wdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_wb got %0b/%0d/%h want 1/7/ffffff80", wb_we, wb_waddr, wb_wdata); end
      checks++; if (dbus_req !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL lb_done got req %0b err %0b want 0/0", dbus_req, err); end
      tick();
   endtask

   task automatic test_store_lanes();
      drive(OP_SB, 32'h2002, 32'h0000_00AB, 1'b1, 1'b0, 5'd0, 32'h0);
      tick();
      checks++; if (dbus_req !== 1'b1 || dbus_we !== 1'b1 || dbus_be !== 4'b0100 || dbus_wdata !== 32'hABAB_ABAB || dbus_addr !== 32'h2000) begin errors++; $display("FAIL sb_bus got req %0b we %0b be %b wdata %h addr %h want 1/1/0100/abababab/00002000", dbus_req, dbus_we, dbus_be, dbus_wdata, dbus_addr); end
      tick();
      checks++; if (dbus_be !== 4'b0100 || dbus_wdata !== 32'hABAB_ABAB || stall !== 1'b1) begin errors++; $display("FAIL sb_hold got be %b wdata %h stall %0b want 0100/abababab/1", dbus_be, dbus_wdata, stall); end
      dbus_ack = 1'b1;
      tick();
      dbus_ack = 1'b0;
      checks++; if (wb_we !== 1'b0 || dbus_req !== 1'b0) begin errors++; $display("FAIL sb_done got wb_we %0b req %0b want 0/0", wb_we, dbus_req); end
      drive(OP_SH, 32'h2002, 32'h5555_1234, 1'b1, 1'b0, 5'd0, 32'h0);
      tick();
      checks++; if (dbus_be !== 4'b1100 || dbus_wdata !== 32'h1234_1234 || dbus_we !== 1'b1) begin errors++; $display("FAIL sh_bus got be %b wdata %h we %0b want 1100/12341234/1", dbus_be, dbus_wdata, dbus_we); end
      dbus_ack = 1'b1;
      tick();
      dbus_ack = 1'b0;
      drive(OP_NONE, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      checks++; if (wb_we !== 1'b0 || dbus_req !== 1'b0) begin errors++; $display("FAIL sh_done got wb_we %0b req %0b want 0/0", wb_we, dbus_req); end
   endtask

   task automatic test_timeout();
      drive(OP_LW, 32'h3000, 32'h0, 1'b0, 1'b1, 5'd9, 32'h0);
      tick();
      for (int i = 0; i < 4; i++) begin
         checks++; if (dbus_req !== 1'b1 || stall !== (i < 3)) begin errors++; $display("FAIL to_wait%0d got req %0b stall %0b want 1/%0b", i, dbus_req, stall, (i < 3)); end
         tick();
      end
      checks++; if (dbus_req !== 1'b0 || err !== 1'b1 || wb_we !== 1'b0) begin errors++; $display("FAIL to_abort got req %0b err %0b wb_we %0b want 0/1/0", dbus_req, err, wb_we); end
   endtask

   task automatic test_back_to_back();
      // Accepted in the IDLE cycle straight after the timeout abort.
      drive(OP_LH, 32'h5002, 32'h0, 1'b0, 1'b1, 5'd3, 32'h0);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_lh_stall got %0b want 1", stall); end
      tick();
      checks++; if (err !== 1'b0 || dbus_req !== 1'b1 || dbus_addr !== 32'h5000) begin errors++; $display("FAIL b2b_lh_bus got err %0b req %0b addr %h want 0/1/00005000", err, dbus_req, dbus_addr); end
      dbus_ack = 1'b1; dbus_rdata = 32'h8001_1234;
      tick();
      dbus_ack = 1'b0;
      checks++; if (wb_we !== 1'b1 || wb_waddr !== 5'd3 || wb_wdata !== 32'hFFFF_8001) begin errors++; $display("FAIL b2b_lh_wb got %0b/%0d/%h want 1/3/ffff8001", wb_we, wb_waddr, wb_wdata); end
      drive(OP_LBU, 32'h5001, 32'h0, 1'b0, 1'b1, 5'd4, 32'h0);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_lbu_stall got %0b want 1", stall); end
      tick();
      dbus_ack = 1'b1; dbus_rdata = 32'h0000_9A00;
      tick();
      dbus_ack = 1'b0;
      checks++; if (wb_we !== 1'b1 || wb_waddr !== 5'd4 || wb_wdata !== 32'h0000_009A) begin errors++; $display("FAIL b2b_lbu_wb got %0b/%0d/%h want 1/4/0000009a", wb_we, wb_waddr, wb_wdata); end
      // Ack in the final timeout cycle completes normally.
      drive(OP_LW, 32'h6000, 32'h0, 1'b0, 1'b1, 5'd6, 32'h0);
      tick();
      for (int i = 0; i < 3; i++) tick();
      dbus_ack = 1'b1; dbus_rdata = 32'hDEAD_BEEF;
      #1;
      checks++; if (stall !== 1'b0 || dbus_req !== 1'b1) begin errors++; $display("FAIL late_ack_stall got stall %0b req %0b want 0/1", stall, dbus_req); end
      tick();
      dbus_ack = 1'b0;
      drive(OP_NONE, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      checks++; if (err !== 1'b0 || wb_we !== 1'b1 || wb_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL late_ack_wb got err %0b wb_we %0b data %h want 0/1/deadbeef", err, wb_we, wb_wdata); end
      tick();
   endtask

   task automatic test_misaligned();
      drive(OP_LW, 32'h4002, 32'h0, 1'b0, 1'b1, 5'd8, 32'h0);
      checks++; if (stall !== 1'b0 || dbus_req !== 1'b0) begin errors++; $display("FAIL mis_stall got stall %0b req %0b want 0/0", stall, dbus_req); end
      tick();
      checks++; if (err !== 1'b1 || wb_we !== 1'b0 || dbus_req !== 1'b0) begin errors++; $display("FAIL mis_err got err %0b wb_we %0b req %0b want 1/0/0", err, wb_we, dbus_req); end
      drive(OP_NONE, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL mis_pulse got %0b want 0", err); end
   endtask

   task automatic test_reset_mid_busy();
      drive(OP_LW, 32'h7000, 32'h0, 1'b0, 1'b1, 5'd10, 32'h0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(OP_NONE, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      checks++; if (dbus_req !== 1'b0 || stall !== 1'b0 || err !== 1'b0 || wb_we !== 1'b0) begin errors++; $display("FAIL rst_mid got req %0b stall %0b err %0b wb_we %0b want 0/0/0/0", dbus_req, stall, err, wb_we); end
      checks++; if (dbus_addr !== 32'h0 || dbus_be !== 4'b0000) begin errors++; $display("FAIL rst_mid_bus got addr %h be %b want 0/0000", dbus_addr, dbus_be); end
      dbus_ack = 1'b1; dbus_rdata = 32'h0000_0001;
      tick();
      dbus_ack = 1'b0;
      checks++; if (wb_we !== 1'b0 || err !== 1'b0 || dbus_req !== 1'b0) begin errors++; $display("FAIL rst_late_ack got wb_we %0b err %0b req %0b want 0/0/0", wb_we, err, dbus_req); end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_lb_sign();
      test_store_lanes();
      test_timeout();
      test_back_to_back();
      test_misaligned();
      test_reset_mid_busy();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
